mem_port_arbiter: RTL

Shares the CPU's single Avalon-MM memory master between the instruction-fetch path, which issues burst reads of `BURST_LENGTH` words, and the load/store path, which issues single-word reads and writes. It sits between `mCpu_ctrl`'s fetch and LW/ST sequencing and the system interconnect. It provides round-robin arbitration, waitrequest handling, burst-beat counting and completion pulses.

---
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Avalon-MM master bus between the arbiter and the system interconnect.
// Handshake: a command (read or write) is accepted on the first rising edge where
// i_m_waitrequest is low; all command fields stay frozen until then. Read data is
// qualified by i_m_readdatavalid alone and may arrive with gaps.
interface mem_port_arbiter_if #(
    parameter int WORD_BITS  = 32,
    parameter int ADDR_BITS  = 32,
    parameter int BURST_BITS = 4
);
    logic [ADDR_BITS-1:0]  o_m_address;
    logic                  o_m_read;
    logic                  o_m_write;
    logic [WORD_BITS-1:0]  o_m_writedata;
    logic [BURST_BITS-1:0] o_m_burstcount;
    logic                  i_m_waitrequest;
    logic [WORD_BITS-1:0]  i_m_readdata;
    logic                  i_m_readdatavalid;

    modport master (
        output o_m_address, o_m_read, o_m_write, o_m_writedata, o_m_burstcount,
        input  i_m_waitrequest, i_m_readdata, i_m_readdatavalid
    );

    modport slave (
        input  o_m_address, o_m_read, o_m_write, o_m_writedata, o_m_burstcount,
        output i_m_waitrequest, i_m_readdata, i_m_readdatavalid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the instruction-fetch
// burst path and the single-word load/store path.
module mem_port_arbiter #(
    parameter int WORD_BITS    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int BURST_LENGTH = 8,
    parameter int BURST_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_f_req,
    input  logic [ADDR_BITS-1:0] i_f_addr,
    output logic                 o_f_grant,
    output logic [WORD_BITS-1:0] o_f_data,
    output logic                 o_f_valid,
    output logic                 o_f_done,
    input  logic                 i_ls_read,
    input  logic                 i_ls_write,
    input  logic [ADDR_BITS-1:0] i_ls_addr,
    input  logic [WORD_BITS-1:0] i_ls_wdata,
    output logic                 o_ls_grant,
    output logic [WORD_BITS-1:0] o_ls_rdata,
    output logic                 o_read_mem_complete,
    output logic                 o_write_mem_complete,
    mem_port_arbiter_if.master   m_bus,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_F_CMD      = 3'd1,
        S_F_DATA     = 3'd2,
        S_LS_RD_CMD  = 3'd3,
        S_LS_RD_DATA = 3'd4,
        S_LS_WR      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    localparam logic [BURST_BITS-1:0] LP_BLEN = BURST_BITS'(BURST_LENGTH);
    localparam logic [BURST_BITS-1:0] LP_LAST = BURST_BITS'(BURST_LENGTH - 1);

    state_t                r_state;
    logic                  r_f_req;
    logic                  r_ls_read;
    logic                  r_ls_write;
    logic                  r_last_ls;
    logic                  r_served_ls;
    logic [BURST_BITS-1:0] r_beat_cnt;
    logic [ADDR_BITS-1:0]  r_m_address;
    logic                  r_m_read;
    logic                  r_m_write;
    logic [WORD_BITS-1:0]  r_m_writedata;
    logic [BURST_BITS-1:0] r_m_burstcount;
    logic                  r_f_grant;
    logic                  r_ls_grant;
    logic [WORD_BITS-1:0]  r_ls_rdata;
    logic                  r_read_complete;
    logic                  r_write_complete;

    logic w_ls_pend;
    logic w_pick_f;
    logic w_f_valid;
    logic w_f_last;

    assign w_ls_pend = r_ls_read | r_ls_write;
    // Fetch wins when alone, or when both are pending and load/store went last.
    assign w_pick_f  = r_f_req & (~w_ls_pend | r_last_ls);
    assign w_f_valid = (r_state == S_F_DATA) & m_bus.i_m_readdatavalid;
    assign w_f_last  = w_f_valid & (r_beat_cnt == LP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_f_req          <= 1'b0;
            r_ls_read        <= 1'b0;
            r_ls_write       <= 1'b0;
            r_last_ls        <= 1'b1;
            r_served_ls      <= 1'b0;
            r_beat_cnt       <= '0;
            r_m_address      <= '0;
            r_m_read         <= 1'b0;
            r_m_write        <= 1'b0;
            r_m_writedata    <= '0;
            r_m_burstcount   <= '0;
            r_f_grant        <= 1'b0;
            r_ls_grant       <= 1'b0;
            r_ls_rdata       <= '0;
            r_read_complete  <= 1'b0;
            r_write_complete <= 1'b0;
        end else begin
            r_f_req          <= i_f_req;
            r_ls_read        <= i_ls_read;
            r_ls_write       <= i_ls_write;
            r_read_complete  <= 1'b0;
            r_write_complete <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pick_f) begin
                        r_m_address    <= i_f_addr;
                        r_m_read       <= 1'b1;
                        r_m_burstcount <= LP_BLEN;
                        r_f_grant      <= 1'b1;
                        r_served_ls    <= 1'b0;
                        r_state        <= S_F_CMD;
                    end else if (w_ls_pend) begin
                        r_m_address    <= i_ls_addr;
                        r_m_burstcount <= BURST_BITS'(1);
                        r_ls_grant     <= 1'b1;
                        r_served_ls    <= 1'b1;
                        if (r_ls_write) begin
                            r_m_write     <= 1'b1;
                            r_m_writedata <= i_ls_wdata;
                            r_state       <= S_LS_WR;
                        end else begin
                            r_m_read <= 1'b1;
                            r_state  <= S_LS_RD_CMD;
                        end
                    end
                end

                S_F_CMD: begin
                    if (!m_bus.i_m_waitrequest) begin
                        r_m_read <= 1'b0;
                        r_state  <= S_F_DATA;
                    end
                end

                S_F_DATA: begin
                    if (w_f_last) begin
                        r_beat_cnt <= '0;
                        r_f_grant  <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (w_f_valid) begin
                        r_beat_cnt <= r_beat_cnt + BURST_BITS'(1);
                    end
                end

                S_LS_RD_CMD: begin
                    if (!m_bus.i_m_waitrequest) begin
                        r_m_read <= 1'b0;
                        r_state  <= S_LS_RD_DATA;
                    end
                end

                S_LS_RD_DATA: begin
                    if (m_bus.i_m_readdatavalid) begin
                        r_ls_rdata      <= m_bus.i_m_readdata;
                        r_read_complete <= 1'b1;
                        r_ls_grant      <= 1'b0;
                        r_state         <= S_DONE;
                    end
                end

                S_LS_WR: begin
                    if (!m_bus.i_m_waitrequest) begin
                        r_m_write        <= 1'b0;
                        r_write_complete <= 1'b1;
                        r_ls_grant       <= 1'b0;
                        r_state          <= S_DONE;
                    end
                end

                S_DONE: begin
                    // The requester may still be holding its level this cycle; forget
                    // the served side so a finished request is never replayed.
                    r_last_ls <= r_served_ls;
                    if (r_served_ls) begin
                        r_ls_read  <= 1'b0;
                        r_ls_write <= 1'b0;
                    end else begin
                        r_f_req <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_bus.o_m_address    = r_m_address;
    assign m_bus.o_m_read       = r_m_read;
    assign m_bus.o_m_write      = r_m_write;
    assign m_bus.o_m_writedata  = r_m_writedata;
    assign m_bus.o_m_burstcount = r_m_burstcount;

    assign o_f_grant            = r_f_grant;
    assign o_f_valid            = w_f_valid;
    assign o_f_data             = w_f_valid ? m_bus.i_m_readdata : '0;
    assign o_f_done             = w_f_last;
    assign o_ls_grant           = r_ls_grant;
    assign o_ls_rdata           = r_ls_rdata;
    assign o_read_mem_complete  = r_read_complete;
    assign o_write_mem_complete = r_write_complete;
    assign o_dbg_state          = r_state;

endmodule
